// File: rtl/muldiv_iter.sv
// muldiv_iter -- iterative RV32M multiply/divide unit (EX-stage companion to the ALU).
//
// Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on operand magnitudes with a
// radix-2 shift-add multiplier and a restoring divider. Signs are re-applied
// once, when CALC finishes. Division by zero and signed overflow are resolved
// at accept time and skip CALC.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      squash any in-flight op; unit returns to IDLE next cycle
//   in_valid   op/a/b valid
//   in_ready   unit can accept (IDLE only)
//   op         RV32M funct3 (0 MUL .. 7 REMU)
//   a, b       rs1 / rs2 operands
//   out_valid  result valid (DONE)
//   out_ready  consumer takes the result
//   result     result, held while out_valid && !out_ready
//   zero       result == 0
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  // Multiply: full product. Divide: low half holds dividend bits shifting
  // out while quotient bits shift in.
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  // Accept-side decode
  logic             a_signed, b_signed, in_sa, in_sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] spec_res;

  always_comb begin
    a_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    in_sa    = a_signed & a[WIDTH-1];
    in_sb    = b_signed & b[WIDTH-1];
    abs_a    = cond_neg_w(in_sa, a);
    abs_b    = cond_neg_w(in_sb, b);
    div_zero = op[2] && (b == '0);
    // Signed overflow only exists for DIV/REM (op 4 and 6).
    div_ovf  = op[2] && !op[0] && (a == MIN_VAL) && (b == '1);
    if (div_zero) spec_res = op[1] ? a : '1;
    else          spec_res = op[1] ? '0 : MIN_VAL;
  end

  // One iteration step of each datapath
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       div_sh, div_diff;
  logic [WIDTH-1:0]     div_rem_nxt, div_quo_nxt;

  always_comb begin
    mul_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                  {1'b0, (prod_q[0] ? mb_q : {WIDTH{1'b0}})};
    mul_nxt     = {mul_sum, prod_q[WIDTH-1:1]};
    div_sh      = {rem_q, prod_q[WIDTH-1]};
    div_diff    = div_sh - {1'b0, mb_q};
    // Bit WIDTH of the difference is the borrow: restore when it is set.
    div_rem_nxt = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_quo_nxt = {prod_q[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  // Finalise from the last step's values, since that step retires on the
  // same edge as CALC->DONE.
  logic [2*WIDTH-1:0] fin_prod;
  logic [WIDTH-1:0]   fin_quo, fin_rem, fin_res;

  always_comb begin
    fin_prod = cond_neg_2w(sa_q ^ sb_q, mul_nxt);
    fin_quo  = cond_neg_w(sa_q ^ sb_q, div_quo_nxt);
    fin_rem  = cond_neg_w(sa_q, div_rem_nxt);
    unique case (op_q)
      3'd0:                 fin_res = fin_prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:     fin_res = fin_prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:           fin_res = fin_quo;
      default:              fin_res = fin_rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    mb_d     = mb_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d   = op;
          sa_d   = in_sa;
          sb_d   = in_sb;
          mb_d   = abs_b;
          prod_d = {{WIDTH{1'b0}}, abs_a};
          rem_d  = '0;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = spec_res;
            zero_d   = (spec_res == '0);
          end else begin
            state_d = S_CALC;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          prod_d = {prod_q[2*WIDTH-1:WIDTH], div_quo_nxt};
          rem_d  = div_rem_nxt;
        end else begin
          prod_d = mul_nxt;
        end
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = fin_res;
          zero_d   = (fin_res == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush beats both accept and handoff; the last result stays visible.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
      zero_d   = zero_q;
    end
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      mb_q        <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      mb_q        <= mb_d;
      prod_q      <= prod_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter -- self-checking bench for muldiv_iter at WIDTH=32 and WIDTH=8.
// Directed RV32M cases, backpressure, flush, async reset, then random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        flush32 = 0, iv32 = 0, or32 = 1;
  logic        ir32, ov32, z32;
  logic [2:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, r32;

  logic        flush8 = 0, iv8 = 0, or8 = 1;
  logic        ir8, ov8, z8;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, r8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush32), .in_valid(iv32), .in_ready(ir32),
    .op(op32), .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32),
    .result(r32), .zero(z32)
  );

  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(iv8), .in_ready(ir8),
    .op(op8), .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
    .result(r8), .zero(z8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics on w-bit values using 64-bit integers.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    longint unsigned msk, au, bu, pu;
    longint          as_, bs_, p, minv;
    logic [63:0]     r;
    msk  = (64'd1 << w) - 64'd1;
    au   = 64'(a) & msk;
    bu   = 64'(b) & msk;
    as_  = longint'(au);
    if (au[w-1]) as_ = as_ - longint'(64'd1 << w);
    bs_  = longint'(bu);
    if (bu[w-1]) bs_ = bs_ - longint'(64'd1 << w);
    minv = -longint'(64'd1 << (w - 1));
    case (op)
      3'd0: begin p = as_ * bs_; r = 64'(p); end
      3'd1: begin p = as_ * bs_; r = 64'(p >>> w); end
      3'd2: begin p = as_ * longint'(bu); r = 64'(p >>> w); end
      3'd3: begin pu = au * bu; r = pu >> w; end
      3'd4: begin
        if (bu == 0) r = msk;
        else if (as_ == minv && bs_ == -1) r = au;
        else r = 64'(as_ / bs_);
      end
      3'd5: r = (bu == 0) ? msk : au / bu;
      3'd6: begin
        if (bu == 0) r = au;
        else if (as_ == minv && bs_ == -1) r = 64'd0;
        else r = 64'(as_ % bs_);
      end
      default: r = (bu == 0) ? au : au % bu;
    endcase
    return 32'(r & msk);
  endfunction

  function automatic bit spec_case(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int w);
    logic [63:0] msk, mn;
    msk = (64'd1 << w) - 64'd1;
    mn  = 64'd1 << (w - 1);
    if (!op[2]) return 1'b0;
    if ((64'(b) & msk) == 64'd0) return 1'b1;
    return ((op == 3'd4) || (op == 3'd6)) && (64'(a) == mn) && (64'(b) == msk);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [63:0] msk;
    logic [31:0] v;
    msk = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = '1;
      2: v = 32'(64'd1 << (w - 1));
      3: v = $urandom_range(0, 9);
      default: v = $urandom;
    endcase
    return v & msk[31:0];
  endfunction

  // Issue one op with out_ready high; returns result, zero flag and the
  // number of edges from the accept edge until out_valid is seen.
  task automatic do_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output logic z,
                       output int lat, output bit ok);
    int n;
    ok = 1'b1; res = '0; z = 1'b0; lat = 0;
    @(negedge clk);
    n = 0;
    while (!(w8 ? ir8 : ir32) && n < 200) begin @(negedge clk); n++; end
    if (!(w8 ? ir8 : ir32)) begin
      check_eq("in_ready_wait", {31'd0, (w8 ? ir8 : ir32)}, 32'd1);
      ok = 1'b0;
      return;
    end
    if (w8) begin op8 = op; a8 = a[7:0]; b8 = b[7:0]; or8 = 1'b1; iv8 = 1'b1; end
    else    begin op32 = op; a32 = a; b32 = b; or32 = 1'b1; iv32 = 1'b1; end
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    lat = 1;
    while (!(w8 ? ov8 : ov32) && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!(w8 ? ov8 : ov32)) begin
      check_eq("out_valid_wait", {31'd0, (w8 ? ov8 : ov32)}, 32'd1);
      ok = 1'b0;
      return;
    end
    res = w8 ? {24'd0, r8} : r32;
    z   = w8 ? z8 : z32;
    @(posedge clk); #1;
    check_eq("handoff_ov", {31'd0, (w8 ? ov8 : ov32)}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t dir [13] = '{
    '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33},
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33},
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
    '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33},
    '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33},
    '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33},
    '{3'd5, 32'd100,      32'd7,        32'd14,       33},
    '{3'd7, 32'd100,      32'd7,        32'd2,        33},
    '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
    '{3'd6, 32'd5,        32'd0,        32'd5,        1},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1},
    '{3'd6, 32'd6,        32'd3,        32'd0,        33}
  };

  initial begin
    logic [31:0] res, exp;
    logic        z;
    int          lat, n, seen, elat;
    bit          ok;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, ir32}, 32'd1);
    check_eq("rst_out_valid", {31'd0, ov32}, 32'd0);
    check_eq("rst_result", r32, 32'd0);
    check_eq("rst_zero", {31'd0, z32}, 32'd1);
    check_eq("rst8_in_ready", {31'd0, ir8}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    for (int i = 0; i < 13; i++) begin
      do_op(1'b0, dir[i].op, dir[i].a, dir[i].b, res, z, lat, ok);
      if (ok) begin
        check_eq($sformatf("dir%0d_result", i), res, dir[i].exp);
        check_eq($sformatf("dir%0d_latency", i), 32'(lat), 32'(dir[i].lat));
        check_eq($sformatf("dir%0d_zero", i), {31'd0, z}, {31'd0, (dir[i].exp == 32'd0)});
      end
    end

    // Backpressure: 123*456 = 0xDB18 held for 10 cycles, extra in_valid ignored
    @(negedge clk);
    op32 = 3'd0; a32 = 32'd123; b32 = 32'd456; or32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    n = 0;
    while (!ov32 && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("bp_valid_seen", {31'd0, ov32}, 32'd1);
    op32 = 3'd4; a32 = 32'd9; b32 = 32'd3; iv32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_result", r32, 32'h0000DB18);
      check_eq("bp_out_valid", {31'd0, ov32}, 32'd1);
      check_eq("bp_in_ready", {31'd0, ir32}, 32'd0);
    end
    @(negedge clk);
    iv32 = 1'b0; or32 = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_ov", {31'd0, ov32}, 32'd0);
    check_eq("bp_release_ir", {31'd0, ir32}, 32'd1);

    // Flush in CALC cycle 5: back to IDLE, result kept, no beat
    @(negedge clk);
    op32 = 3'd5; a32 = 32'd1000; b32 = 32'd3; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0;
    check_eq("flush_in_ready", {31'd0, ir32}, 32'd1);
    check_eq("flush_out_valid", {31'd0, ov32}, 32'd0);
    check_eq("flush_result", r32, 32'h0000DB18);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ov32) seen++; end
    check_eq("flush_no_beat", 32'(seen), 32'd0);

    // Flush beats a simultaneous accept
    @(negedge clk);
    op32 = 3'd5; a32 = 32'd9; b32 = 32'd3; iv32 = 1'b1; flush32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; flush32 = 1'b0;
    check_eq("flush_prio_ir", {31'd0, ir32}, 32'd1);
    @(posedge clk); #1;
    check_eq("flush_prio_ir2", {31'd0, ir32}, 32'd1);

    // Async reset mid-CALC
    @(negedge clk);
    op32 = 3'd0; a32 = 32'd3; b32 = 32'd5; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_in_ready", {31'd0, ir32}, 32'd1);
    check_eq("arst_out_valid", {31'd0, ov32}, 32'd0);
    check_eq("arst_result", r32, 32'd0);
    check_eq("arst_zero", {31'd0, z32}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Random, WIDTH=32
    for (int i = 0; i < 600; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = pick(32);
      rb   = pick(32);
      exp  = ref_model(rop, ra, rb, 32);
      elat = spec_case(rop, ra, rb, 32) ? 1 : 33;
      do_op(1'b0, rop, ra, rb, res, z, lat, ok);
      if (ok) begin
        check_eq($sformatf("r32_%0d_op%0d_res", i, rop), res, exp);
        check_eq($sformatf("r32_%0d_lat", i), 32'(lat), 32'(elat));
        check_eq($sformatf("r32_%0d_zero", i), {31'd0, z}, {31'd0, (exp == 32'd0)});
      end
    end

    // Random, WIDTH=8
    for (int i = 0; i < 2000; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = pick(8);
      rb   = pick(8);
      exp  = ref_model(rop, ra, rb, 8);
      elat = spec_case(rop, ra, rb, 8) ? 1 : 9;
      do_op(1'b1, rop, ra, rb, res, z, lat, ok);
      if (ok) begin
        check_eq($sformatf("r8_%0d_op%0d_res", i, rop), res, exp);
        check_eq($sformatf("r8_%0d_lat", i), 32'(lat), 32'(elat));
        check_eq($sformatf("r8_%0d_zero", i), {31'd0, z}, {31'd0, (exp == 32'd0)});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
